eth_tx: RTL and testbench

- RMII transmit MAC for the 50 MHz Ethernet clock domain; the outbound counterpart of the ether/bitorder/cksum receive chain.
- Accepts a frame as a byte stream (destination MAC through payload) and emits preamble, SFD, payload, zero padding, FCS and inter-frame gap on txen/txd.
- Dibits are sent LSB-first, so the receive side reassembles them unchanged.

---
 rtl/eth_tx_pkg.sv | 20 ++
 rtl/eth_tx_crc32_dibit.sv | 18 +
 rtl/eth_tx.sv | 212 +++++++++++++++++++++
 tb/tb_eth_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// Shared definitions for the RMII transmit path: FSM states, framing bytes
// and CRC-32 constants.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
        PAD,
        FCS,
        IFG
    } eth_tx_state_e;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD           = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;

endpackage

// File: rtl/eth_tx_crc32_dibit.sv
// Combinational reflected CRC-32 step over one dibit, bit 0 first.
// Shared with the receive-side checksum block.
module eth_tx_crc32_dibit
    import eth_tx_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [1:0]  i_dibit,
    output logic [31:0] o_crc
);

    logic [31:0] w_c0;
    logic [31:0] w_c1;

    assign w_c0  = (i_crc[0] ^ i_dibit[0]) ? ((i_crc >> 1) ^ ETH_CRC_POLY) : (i_crc >> 1);
    assign w_c1  = (w_c0[0] ^ i_dibit[1]) ? ((w_c0 >> 1) ^ ETH_CRC_POLY) : (w_c0 >> 1);
    assign o_crc = w_c1;

endmodule

// File: rtl/eth_tx.sv
// RMII transmit MAC: wraps a byte stream with preamble, SFD, zero padding,
// FCS and inter-frame gap, emitting one LSB-first dibit per clock.
module eth_tx
    import eth_tx_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_CYCLES      = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [7:0] axiid,
    input  logic       axiilast,
    output logic       axiir,
    output logic       txen,
    output logic [1:0] txd,
    output logic       busy,
    output logic       underrun
);

    // Handshake: a byte moves only on a cycle where axiiv and axiir are both
    // high; axiir is raised for exactly the final dibit of the current byte.

    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
    localparam logic [11:0] MIN_B    = 12'(MIN_FRAME_BYTES);

    eth_tx_state_e r_state;
    logic [1:0]    r_d;
    logic [7:0]    r_cnt;
    logic [7:0]    r_sh;
    logic [31:0]   r_fcs;
    logic          r_last;
    logic [10:0]   r_bytes;
    logic [31:0]   r_crc;
    logic          r_axiir;
    logic          r_txen;
    logic [1:0]    r_txd;
    logic          r_busy;
    logic          r_underrun;

    logic [1:0]    w_crc_dibit;
    logic [31:0]   w_crc_next;
    logic [1:0]    w_d_nxt;
    logic [10:0]   w_bytes_inc;
    logic [11:0]   w_diff;
    logic          w_short;

    eth_tx_crc32_dibit u_crc (
        .i_crc   (r_crc),
        .i_dibit (w_crc_dibit),
        .o_crc   (w_crc_next)
    );

    // The CRC advances on the edge that puts a payload or pad dibit on txd.
    always_comb begin
        w_crc_dibit = 2'b00;
        case (r_state)
            SFD:     w_crc_dibit = axiid[1:0];
            PAYLOAD: w_crc_dibit = (r_d != 2'd3) ? r_sh[1:0] :
                                   (r_last ? 2'b00 : axiid[1:0]);
            default: w_crc_dibit = 2'b00;
        endcase
    end

    assign w_d_nxt     = r_d + 2'd1;
    assign w_bytes_inc = (r_bytes == 11'h7FF) ? r_bytes : r_bytes + 11'd1;
    assign w_diff      = {1'b0, r_bytes} - MIN_B;
    assign w_short     = w_diff[11];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_d        <= 2'd0;
            r_cnt      <= 8'd0;
            r_sh       <= 8'd0;
            r_fcs      <= 32'd0;
            r_last     <= 1'b0;
            r_bytes    <= 11'd0;
            r_crc      <= ETH_CRC_INIT;
            r_axiir    <= 1'b0;
            r_txen     <= 1'b0;
            r_txd      <= 2'b00;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_axiir    <= 1'b0;
            r_underrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_txen <= 1'b0;
                    r_txd  <= 2'b00;
                    if (axiiv) begin
                        r_state <= PREAMBLE;
                        r_cnt   <= 8'd0;
                        r_bytes <= 11'd0;
                        r_txen  <= 1'b1;
                        r_txd   <= ETH_PREAMBLE_BYTE[1:0];
                        r_busy  <= 1'b1;
                    end
                end
                PREAMBLE: begin
                    if (r_cnt == 8'd27) begin
                        r_state <= SFD;
                        r_d     <= 2'd0;
                        r_txd   <= ETH_SFD[1:0];
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        r_txd <= ETH_PREAMBLE_BYTE[1:0];
                    end
                end
                SFD, PAYLOAD: begin
                    if (r_d != 2'd3) begin
                        r_d <= w_d_nxt;
                        if (r_state == SFD) begin
                            r_txd <= ETH_SFD[{w_d_nxt, 1'b0} +: 2];
                            r_axiir <= (r_d == 2'd2);
                        end else begin
                            r_txd   <= r_sh[1:0];
                            r_sh    <= r_sh >> 2;
                            r_crc   <= w_crc_next;
                            r_axiir <= (r_d == 2'd2) && !r_last;
                        end
                    end else if (r_state == SFD || !r_last) begin
                        if (axiiv) begin
                            r_state <= PAYLOAD;
                            r_d     <= 2'd0;
                            r_txd   <= axiid[1:0];
                            r_sh    <= {2'b00, axiid[7:2]};
                            r_last  <= axiilast;
                            r_bytes <= w_bytes_inc;
                            r_crc   <= w_crc_next;
                        end else begin
                            // Source starved on a fetch: abandon the frame without FCS.
                            r_underrun <= 1'b1;
                            r_state    <= IFG;
                            r_cnt      <= 8'd0;
                            r_txen     <= 1'b0;
                            r_txd      <= 2'b00;
                            r_crc      <= ETH_CRC_INIT;
                        end
                    end else if (w_short) begin
                        r_state <= PAD;
                        r_d     <= 2'd0;
                        r_txd   <= 2'b00;
                        r_bytes <= w_bytes_inc;
                        r_crc   <= w_crc_next;
                    end else begin
                        r_state <= FCS;
                        r_cnt   <= 8'd0;
                        r_txd   <= ~r_crc[1:0];
                        r_fcs   <= (~r_crc) >> 2;
                    end
                end
                PAD: begin
                    if (r_d != 2'd3) begin
                        r_d   <= w_d_nxt;
                        r_txd <= 2'b00;
                        r_crc <= w_crc_next;
                    end else if (w_short) begin
                        r_d     <= 2'd0;
                        r_txd   <= 2'b00;
                        r_bytes <= w_bytes_inc;
                        r_crc   <= w_crc_next;
                    end else begin
                        r_state <= FCS;
                        r_cnt   <= 8'd0;
                        r_txd   <= ~r_crc[1:0];
                        r_fcs   <= (~r_crc) >> 2;
                    end
                end
                FCS: begin
                    if (r_cnt == 8'd15) begin
                        r_state <= IFG;
                        r_cnt   <= 8'd0;
                        r_txen  <= 1'b0;
                        r_txd   <= 2'b00;
                        r_crc   <= ETH_CRC_INIT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        r_txd <= r_fcs[1:0];
                        r_fcs <= r_fcs >> 2;
                    end
                end
                IFG: begin
                    r_crc <= ETH_CRC_INIT;
                    if (r_cnt == IFG_LAST) begin
                        if (axiiv) begin
                            r_state <= PREAMBLE;
                            r_cnt   <= 8'd0;
                            r_bytes <= 11'd0;
                            r_txen  <= 1'b1;
                            r_txd   <= ETH_PREAMBLE_BYTE[1:0];
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign axiir    = r_axiir;
    assign txen     = r_txen;
    assign txd      = r_txd;
    assign busy     = r_busy;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_eth_tx.sv
// Directed bench for eth_tx: one unpadded and one padded instance share a
// byte driver; a monitor pops expected dibits as txen cycles appear.
module tb_eth_tx;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       axiiv;
    logic [7:0] axiid;
    logic       axiilast;

    logic       axiiv0, axiiv1;
    logic       axiir0, axiir1, txen0, txen1, busy0, busy1, und0, und1;
    logic [1:0] txd0, txd1;
    logic       axiir_m, txen_m, busy_m, und_m;
    logic [1:0] txd_m;

    logic [8:0]  in_q[$];
    logic [1:0]  exp_q[$];
    logic [7:0]  fb[$];
    int          errors = 0;
    int          checks = 0;
    int          taken = 0;
    int          gap_at = -1;
    logic        hold = 1'b0;

    assign axiiv0  = axiiv & ~sel;
    assign axiiv1  = axiiv & sel;
    assign axiir_m = sel ? axiir1 : axiir0;
    assign txen_m  = sel ? txen1 : txen0;
    assign txd_m   = sel ? txd1 : txd0;
    assign busy_m  = sel ? busy1 : busy0;
    assign und_m   = sel ? und1 : und0;

    eth_tx #(.MIN_FRAME_BYTES(0), .IFG_CYCLES(48)) dut0 (
        .clk(clk), .rst(rst), .axiiv(axiiv0), .axiid(axiid), .axiilast(axiilast),
        .axiir(axiir0), .txen(txen0), .txd(txd0), .busy(busy0), .underrun(und0)
    );

    eth_tx #(.MIN_FRAME_BYTES(60), .IFG_CYCLES(48)) dut1 (
        .clk(clk), .rst(rst), .axiiv(axiiv1), .axiid(axiid), .axiilast(axiilast),
        .axiir(axiir1), .txen(txen1), .txd(txd1), .busy(busy1), .underrun(und1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if ((c[0] ^ b[i]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
            else                       c = c >> 1;
        end
        return c;
    endfunction

    task automatic push_byte_dibits(input logic [7:0] b);
        for (int k = 0; k < 4; k++) exp_q.push_back(b[2*k +: 2]);
    endtask

    // driver: queues fb as a frame and builds its expected wire dibits
    task automatic queue_frame(input int min_b, input int keep, input bit use_fixed,
                               input logic [31:0] fcs_fixed);
        logic [31:0] crc;
        logic [31:0] fcs;
        int n;
        n = fb.size();
        for (int i = 0; i < 28; i++) exp_q.push_back(2'b01);
        exp_q.push_back(2'b01); exp_q.push_back(2'b01);
        exp_q.push_back(2'b01); exp_q.push_back(2'b11);
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            in_q.push_back({(i == n - 1), fb[i]});
            if (keep < 0 || i < keep) push_byte_dibits(fb[i]);
            crc = crc_byte(crc, fb[i]);
        end
        if (keep < 0) begin
            for (int i = n; i < min_b; i++) begin
                push_byte_dibits(8'h00);
                crc = crc_byte(crc, 8'h00);
            end
            fcs = use_fixed ? fcs_fixed : ~crc;
            for (int k = 0; k < 16; k++) exp_q.push_back(fcs[2*k +: 2]);
        end
    endtask

    task automatic fill_fb(input int n, input logic [7:0] seed);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(seed + 8'(i * 7));
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Called on a negedge; returns on the first txen-low negedge after a frame.
    task automatic wait_frame(output int len, output int rp, output int up);
        bit seen;
        bit done;
        seen = 0; done = 0; len = 0; rp = 0; up = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (txen_m) begin len++; seen = 1; end
            if (axiir_m) rp++;
            if (und_m) up++;
            if (seen && !txen_m) done = 1;
            else @(negedge clk);
        end
        if (!done) begin
            checks++; errors++;
            $error("FAIL frame_timeout: observed no frame end, expected one within 3000 cycles");
        end
    endtask

    task automatic count_low(output int low);
        low = 0;
        for (int cyc = 0; cyc < 500 && !txen_m; cyc++) begin
            low++;
            @(negedge clk);
        end
    endtask

    task automatic check_ifg(input string tag);
        int ok;
        ok = 0;
        for (int i = 0; i < 48; i++) begin
            if (busy_m === 1'b1 && txen_m === 1'b0 && txd_m === 2'b00) ok++;
            @(negedge clk);
        end
        chk({tag, "_ifg_busy"}, ok, 48);
        chk({tag, "_idle_busy"}, int'(busy_m), 0);
    endtask

    // driver process: presents the head of in_q, pops on handshake
    initial begin
        bit take;
        axiiv = 1'b0; axiid = 8'h00; axiilast = 1'b0;
        forever begin
            @(negedge clk);
            take = axiiv && axiir_m && rst;
            @(posedge clk);
            #1;
            if (take && in_q.size() > 0) begin
                in_q.delete(0);
                taken++;
            end
            if (axiir_m && taken == gap_at && !hold) hold = 1'b1;
            if (!hold && in_q.size() > 0) begin
                axiiv = 1'b1;
                {axiilast, axiid} = in_q[0];
            end else begin
                axiiv = 1'b0; axiilast = 1'b0; axiid = 8'h00;
            end
        end
    end

    // scoreboard monitor: one expected dibit per txen cycle
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (rst && txen_m) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL dibit: observed txd=%b with nothing expected", txd_m);
                end else begin
                    e = exp_q.pop_front();
                    assert (txd_m === e) else begin
                        errors++;
                        $error("FAIL dibit: observed %b expected %b", txd_m, e);
                    end
                end
            end
        end
    end

    initial begin
        int len, rp, up, low;
        sel = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txen", int'(txen0), 0);
        chk("rst_txd", int'(txd0), 0);
        chk("rst_axiir", int'(axiir1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_underrun", int'(und0 | und1), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // "123456789", no padding, known FCS 26 39 F4 CB
        fb.delete();
        for (int i = 0; i < 9; i++) fb.push_back(8'h31 + 8'(i));
        taken = 0;
        queue_frame(0, -1, 1'b1, 32'hCBF43926);
        wait_frame(len, rp, up);
        chk("check_len", len, 84);
        chk("check_axiir", rp, 9);
        chk("check_exp_left", exp_q.size(), 0);
        check_ifg("check");

        // single byte, padded to 60
        sel = 1'b1;
        @(negedge clk);
        fb.delete(); fb.push_back(8'hA5);
        taken = 0;
        queue_frame(60, -1, 1'b0, 32'h0);
        wait_frame(len, rp, up);
        chk("pad1_len", len, 288);
        chk("pad1_axiir", rp, 1);
        chk("pad1_exp_left", exp_q.size(), 0);
        check_ifg("pad1");

        // 0xB4 leads: dibits 00 01 11 10
        sel = 1'b0;
        @(negedge clk);
        fb.delete(); fb.push_back(8'hB4); fb.push_back(8'h3C); fb.push_back(8'hFF);
        taken = 0;
        queue_frame(0, -1, 1'b0, 32'h0);
        wait_frame(len, rp, up);
        chk("b4_len", len, 60);
        chk("b4_exp_left", exp_q.size(), 0);
        check_ifg("b4");

        // starve the 3rd fetch: abort after 2 bytes on the wire
        fill_fb(6, 8'h10);
        taken = 0; gap_at = 2;
        queue_frame(0, 2, 1'b0, 32'h0);
        wait_frame(len, rp, up);
        chk("urun_len", len, 40);
        chk("urun_pulse", up, 1);
        chk("urun_txen_low", int'(und_m && !txen_m), 1);
        in_q.delete(); gap_at = -1; hold = 1'b0;
        chk("urun_exp_left", exp_q.size(), 0);
        exp_q.delete();
        check_ifg("urun");
        fill_fb(5, 8'h80);
        taken = 0;
        queue_frame(0, -1, 1'b0, 32'h0);
        wait_frame(len, rp, up);
        chk("post_urun_len", len, 68);
        chk("post_urun_under", up, 0);
        chk("post_urun_exp_left", exp_q.size(), 0);
        check_ifg("post_urun");

        // two back-to-back 64-byte frames
        sel = 1'b1;
        @(negedge clk);
        fill_fb(64, 8'h21);
        taken = 0;
        queue_frame(60, -1, 1'b0, 32'h0);
        fill_fb(64, 8'h5A);
        queue_frame(60, -1, 1'b0, 32'h0);
        wait_frame(len, rp, up);
        chk("b2b1_len", len, 304);
        count_low(low);
        chk("b2b_gap", low, 48);
        wait_frame(len, rp, up);
        chk("b2b2_len", len, 304);
        chk("b2b_exp_left", exp_q.size(), 0);
        check_ifg("b2b");

        // asynchronous reset in the middle of the payload
        fill_fb(20, 8'h44);
        taken = 0;
        queue_frame(60, -1, 1'b0, 32'h0);
        repeat (60) @(negedge clk);
        chk("pre_rst_txen", int'(txen_m), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_txen", int'(txen1), 0);
        chk("arst_txd", int'(txd1), 0);
        chk("arst_axiir", int'(axiir1), 0);
        chk("arst_busy", int'(busy1), 0);
        in_q.delete(); exp_q.delete(); hold = 1'b0; gap_at = -1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fill_fb(10, 8'hC3);
        taken = 0;
        queue_frame(60, -1, 1'b0, 32'h0);
        wait_frame(len, rp, up);
        chk("post_rst_len", len, 288);
        chk("post_rst_exp_left", exp_q.size(), 0);
        check_ifg("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
